// File: rtl/block_pipe_pkg.sv
// block_pipe_pkg: widths and beat type shared by the block distributor and reorder collector
package block_pipe_pkg;
    localparam int DEFAULT_BLOCK_WIDTH = 32;
    localparam int DEFAULT_SEQUENCE_ID_WIDTH = 8;
    typedef struct packed {
        logic [DEFAULT_BLOCK_WIDTH-1:0] data;
        logic [DEFAULT_SEQUENCE_ID_WIDTH-1:0] seq_id;
    } lane_beat_t;
endpackage

// File: rtl/block_reorder_collector_if.sv
// block_reorder_collector_if: tagged lane inputs and in-order output stream of the reorder collector
interface block_reorder_collector_if #(
    parameter int BLOCK_WIDTH = block_pipe_pkg::DEFAULT_BLOCK_WIDTH,
    parameter int NUM_LANES = 4,
    parameter int SEQUENCE_ID_WIDTH = block_pipe_pkg::DEFAULT_SEQUENCE_ID_WIDTH,
    parameter int ROB_DEPTH = 8
);
    logic [BLOCK_WIDTH-1:0] lane_data [NUM_LANES];
    logic [SEQUENCE_ID_WIDTH-1:0] lane_seq_id [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_ready;
    logic [BLOCK_WIDTH-1:0] data_out;
    logic [SEQUENCE_ID_WIDTH-1:0] data_out_seq_id;
    logic data_out_valid;
    logic data_out_ready;
    logic [$clog2(ROB_DEPTH+1)-1:0] occupancy;
    logic seq_error;
    modport master (
        output lane_data, lane_seq_id, lane_valid, data_out_ready,
        input lane_ready, data_out, data_out_seq_id, data_out_valid, occupancy, seq_error
    );
    modport slave (
        input lane_data, lane_seq_id, lane_valid, data_out_ready,
        output lane_ready, data_out, data_out_seq_id, data_out_valid, occupancy, seq_error
    );
endinterface

// File: rtl/seq_window_check.sv
// seq_window_check: classifies one lane tag against the reorder window and slot occupancy
module seq_window_check #(
    parameter int SEQUENCE_ID_WIDTH = block_pipe_pkg::DEFAULT_SEQUENCE_ID_WIDTH,
    parameter int ROB_DEPTH = 8
) (
    input logic [SEQUENCE_ID_WIDTH-1:0] tag,
    input logic [SEQUENCE_ID_WIDTH-1:0] expected_seq,
    input logic [ROB_DEPTH-1:0] occupied,
    output logic in_window,
    output logic [$clog2(ROB_DEPTH)-1:0] slot,
    output logic duplicate
);
    localparam int IW = $clog2(ROB_DEPTH);
    logic [SEQUENCE_ID_WIDTH-1:0] offset;
    assign offset = tag - expected_seq;
    // power-of-two depth: offset < ROB_DEPTH exactly when the bits above the slot index are zero
    assign in_window = (offset >> IW) == '0;
    assign slot = tag[IW-1:0];
    assign duplicate = in_window & occupied[slot];
endmodule

// File: rtl/block_reorder_collector.sv
// block_reorder_collector: merges tagged lane results into one stream in strict sequence order
module block_reorder_collector #(
    parameter int BLOCK_WIDTH = block_pipe_pkg::DEFAULT_BLOCK_WIDTH,
    parameter int NUM_LANES = 4,
    parameter int SEQUENCE_ID_WIDTH = block_pipe_pkg::DEFAULT_SEQUENCE_ID_WIDTH,
    parameter int ROB_DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    block_reorder_collector_if.slave bus
);
    localparam int IW = $clog2(ROB_DEPTH);
    localparam int OW = $clog2(ROB_DEPTH + 1);
    logic [SEQUENCE_ID_WIDTH-1:0] expected_seq;
    logic [ROB_DEPTH-1:0] occ, occ_next;
    logic [BLOCK_WIDTH-1:0] slot_data [ROB_DEPTH];
    logic [SEQUENCE_ID_WIDTH-1:0] slot_seq [ROB_DEPTH];
    logic [OW-1:0] occupancy, occupancy_next;
    logic seq_error;
    logic [NUM_LANES-1:0] in_window, duplicate, claim, accept, ready;
    logic [IW-1:0] slot [NUM_LANES];
    logic [IW-1:0] head;
    logic pop, dup_hit;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        seq_window_check #(
            .SEQUENCE_ID_WIDTH(SEQUENCE_ID_WIDTH),
            .ROB_DEPTH(ROB_DEPTH)
        ) u_check (
            .tag(bus.lane_seq_id[i]),
            .expected_seq(expected_seq),
            .occupied(occ),
            .in_window(in_window[i]),
            .slot(slot[i]),
            .duplicate(duplicate[i])
        );
    end

    // a fresh in-window tag goes to the lowest valid lane offering it; higher lanes wait a cycle and then see a duplicate
    always_comb begin
        claim = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            claim[i] = in_window[i] & ~duplicate[i];
            for (int j = 0; j < i; j++)
                if (bus.lane_valid[j] && claim[j] && slot[j] == slot[i]) claim[i] = 1'b0;
        end
        accept = claim & bus.lane_valid;
        ready = {NUM_LANES{rst_n}} & (claim | duplicate);
        dup_hit = |(bus.lane_valid & duplicate);
    end

    assign head = expected_seq[IW-1:0];
    assign pop = occ[head] & bus.data_out_ready;

    always_comb begin
        occ_next = occ;
        occupancy_next = occupancy - OW'(pop);
        if (pop) occ_next[head] = 1'b0;
        for (int i = 0; i < NUM_LANES; i++)
            if (accept[i]) begin
                occ_next[slot[i]] = 1'b1;
                occupancy_next = occupancy_next + OW'(1);
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_seq <= '0;
            occ <= '0;
            occupancy <= '0;
            seq_error <= 1'b0;
            for (int k = 0; k < ROB_DEPTH; k++) begin
                slot_data[k] <= '0;
                slot_seq[k] <= '0;
            end
        end else begin
            occ <= occ_next;
            occupancy <= occupancy_next;
            if (pop) expected_seq <= expected_seq + SEQUENCE_ID_WIDTH'(1);
            if (dup_hit) seq_error <= 1'b1;
            for (int i = 0; i < NUM_LANES; i++)
                if (accept[i]) begin
                    slot_data[slot[i]] <= bus.lane_data[i];
                    slot_seq[slot[i]] <= bus.lane_seq_id[i];
                end
        end
    end

    assign bus.lane_ready = ready;
    assign bus.data_out = slot_data[head];
    assign bus.data_out_seq_id = slot_seq[head];
    assign bus.data_out_valid = occ[head];
    assign bus.occupancy = occupancy;
    assign bus.seq_error = seq_error;
endmodule

// File: tb/tb_block_reorder_collector.sv
// tb_block_reorder_collector: directed self-checking bench for the reorder collector
module tb_block_reorder_collector;
    localparam int BW = 32;
    localparam int NL = 4;
    localparam int SW = 8;
    localparam int RD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    block_reorder_collector_if #(
        .BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW), .ROB_DEPTH(RD)
    ) bus ();

    block_reorder_collector #(
        .BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW), .ROB_DEPTH(RD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lane_valid = '0;
    endtask

    task automatic put(input int lane, input logic [SW-1:0] tag, input logic [BW-1:0] data);
        bus.lane_valid[lane] = 1'b1;
        bus.lane_seq_id[lane] = tag;
        bus.lane_data[lane] = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        bus.data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.data_out_valid, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_err", bus.seq_error, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc, si, oi;
        logic prev_v, prev_r;
        logic [BW-1:0] prev_d;
        logic [SW-1:0] prev_s;
        bus.lane_valid = '0;
        bus.data_out_ready = 1'b0;
        for (int i = 0; i < NL; i++) begin
            bus.lane_data[i] = '0;
            bus.lane_seq_id[i] = '0;
        end
        // reset values, with a lane offering tag 0 while reset is held
        put(0, 8'd0, 32'h1234);
        #2;
        check("rst0_ready", bus.lane_ready, 4'h0);
        check("rst0_valid", bus.data_out_valid, 0);
        check("rst0_occ", bus.occupancy, 0);
        check("rst0_err", bus.seq_error, 0);
        check("rst0_data", bus.data_out, 0);
        check("rst0_seq", bus.data_out_seq_id, 0);
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // in-order: four lanes, tags 0..3 in one cycle
        bus.data_out_ready = 1'b1;
        for (int i = 0; i < NL; i++) put(i, SW'(i), 32'hA000_0000 + i);
        #1 check("inorder_ready", bus.lane_ready, 4'hF);
        tick();
        idle();
        check("inorder_peak", bus.occupancy, 4);
        for (int k = 0; k < 4; k++) begin
            check("inorder_valid", bus.data_out_valid, 1);
            check("inorder_seq", bus.data_out_seq_id, k);
            check("inorder_data", bus.data_out, 32'hA000_0000 + k);
            tick();
        end
        check("inorder_empty", bus.data_out_valid, 0);
        check("inorder_occ0", bus.occupancy, 0);

        // out of order: 2, 1, then 0
        do_reset();
        bus.data_out_ready = 1'b1;
        put(0, 8'd2, 32'hB000_0002);
        tick();
        idle();
        check("ooo_hold2", bus.data_out_valid, 0);
        put(1, 8'd1, 32'hB000_0001);
        tick();
        idle();
        check("ooo_hold1", bus.data_out_valid, 0);
        check("ooo_occ2", bus.occupancy, 2);
        put(2, 8'd0, 32'hB000_0000);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            check("ooo_valid", bus.data_out_valid, 1);
            check("ooo_seq", bus.data_out_seq_id, k);
            check("ooo_data", bus.data_out, 32'hB000_0000 + k);
            tick();
        end
        check("ooo_empty", bus.data_out_valid, 0);

        // window stall: tag 8 against expected 0
        do_reset();
        put(0, 8'd0, 32'hC000_0000);
        tick();
        idle();
        put(1, 8'd8, 32'hC000_0008);
        #1 check("stall_ready_a", bus.lane_ready[1], 0);
        tick();
        check("stall_ready_b", bus.lane_ready[1], 0);
        check("stall_head", bus.data_out_valid, 1);
        bus.data_out_ready = 1'b1;
        #1 check("stall_ready_pop", bus.lane_ready[1], 0);
        tick();
        bus.data_out_ready = 1'b0;
        #1 check("stall_ready_open", bus.lane_ready[1], 1);
        tick();
        idle();
        check("stall_occ", bus.occupancy, 1);
        check("stall_nohead", bus.data_out_valid, 0);

        // duplicate tag 3, then same tag on two lanes in one cycle
        do_reset();
        put(0, 8'd3, 32'hD000_0003);
        tick();
        idle();
        put(2, 8'd3, 32'hDEAD_BEEF);
        #1 check("dup_ready", bus.lane_ready[2], 1);
        check("dup_err_before", bus.seq_error, 0);
        tick();
        idle();
        check("dup_err", bus.seq_error, 1);
        check("dup_occ", bus.occupancy, 1);
        put(0, 8'd0, 32'hD000_0000);
        put(1, 8'd1, 32'hD000_0001);
        put(2, 8'd2, 32'hD000_0002);
        tick();
        idle();
        bus.data_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("dup_seq", bus.data_out_seq_id, k);
            check("dup_data", bus.data_out, 32'hD000_0000 + k);
            tick();
        end
        check("dup_single", bus.data_out_valid, 0);
        bus.data_out_ready = 1'b0;
        put(0, 8'd4, 32'hE000_0000);
        put(1, 8'd4, 32'hE000_0001);
        #1 check("tie_ready", bus.lane_ready[1:0], 2'b01);
        tick();
        bus.lane_valid[0] = 1'b0;
        #1 check("tie_dup_ready", bus.lane_ready[1], 1);
        tick();
        idle();
        check("tie_data", bus.data_out, 32'hE000_0000);
        check("tie_occ", bus.occupancy, 1);

        // mid-stream reset with five slots filled
        for (int i = 0; i < NL; i++) put(i, SW'(5 + i), 32'h7000_0000 + i);
        tick();
        idle();
        check("mrst_fill", bus.occupancy, 5);
        rst_n = 1'b0;
        put(0, 8'd0, 32'h7777);
        #1 check("mrst_valid", bus.data_out_valid, 0);
        check("mrst_occ", bus.occupancy, 0);
        check("mrst_err", bus.seq_error, 0);
        check("mrst_data", bus.data_out, 0);
        check("mrst_ready", bus.lane_ready[0], 0);
        repeat (3) @(posedge clk);
        #1 check("mrst_hold_occ", bus.occupancy, 0);
        rst_n = 1'b1;
        idle();
        put(3, 8'd0, 32'hF000_0000);
        bus.data_out_ready = 1'b1;
        #1 check("mrst_accept", bus.lane_ready[3], 1);
        tick();
        idle();
        check("mrst_first_valid", bus.data_out_valid, 1);
        check("mrst_first_seq", bus.data_out_seq_id, 0);
        check("mrst_first_data", bus.data_out, 32'hF000_0000);
        tick();
        check("mrst_drained", bus.data_out_valid, 0);

        // advance expected_seq to 250, one tag per cycle
        do_reset();
        bus.data_out_ready = 1'b1;
        sent = 0;
        cyc = 0;
        while ((sent < 250 || bus.data_out_valid) && cyc < 1000) begin
            idle();
            if (sent < 250) put(0, SW'(sent), 32'h6000_0000 + sent);
            #1;
            if (sent < 250 && bus.lane_ready[0]) sent++;
            tick();
            cyc++;
        end
        idle();
        check("pump_sent", sent, 250);
        check("pump_empty", bus.data_out_valid, 0);

        // wrap 250..255, 0..5 with data_out_ready toggling every cycle
        si = 0;
        oi = 0;
        cyc = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = '0;
        prev_s = '0;
        while ((si < 12 || oi < 12) && cyc < 200) begin
            bus.data_out_ready = (cyc % 2) == 1;
            idle();
            if (si < 12) put(si % 4, SW'(250 + si), 32'h5000_0000 + ((250 + si) % 256));
            #1;
            if (prev_v && !prev_r) begin
                check("hold_valid", bus.data_out_valid, 1);
                check("hold_seq", bus.data_out_seq_id, prev_s);
                check("hold_data", bus.data_out, prev_d);
            end
            if (bus.data_out_valid && bus.data_out_ready) begin
                check("wrap_seq", bus.data_out_seq_id, (250 + oi) % 256);
                check("wrap_data", bus.data_out, 32'h5000_0000 + ((250 + oi) % 256));
                oi++;
            end
            if (si < 12 && bus.lane_ready[si % 4]) si++;
            prev_v = bus.data_out_valid;
            prev_r = bus.data_out_ready;
            prev_d = bus.data_out;
            prev_s = bus.data_out_seq_id;
            tick();
            cyc++;
        end
        idle();
        check("wrap_count", oi, 12);
        check("wrap_empty", bus.data_out_valid, 0);
        check("wrap_occ", bus.occupancy, 0);
        check("wrap_noerr", bus.seq_error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_reorder_collector.md
# block_reorder_collector

Downstream stage of `block_distributor`. It gathers the per-lane results produced by the parallel processing lanes, each tagged with the sequence ID the distributor assigned. It emits them as one stream in strict sequence-ID order, and a small reorder buffer absorbs the differences in lane latency.

## Interface
Parameters:
- `BLOCK_WIDTH`, default 32: payload width.
- `NUM_LANES`, default 4: number of input lanes.
- `SEQUENCE_ID_WIDTH`, default 8: sequence ID width; IDs wrap modulo 2^`SEQUENCE_ID_WIDTH`.
- `ROB_DEPTH`, default 8: reorder slots.
  - Must be a power of two, ≥ `NUM_LANES`, and ≤ 2^(`SEQUENCE_ID_WIDTH`-1).

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk`, input, 1: sole clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
- `lane_data`, input, `BLOCK_WIDTH` x `NUM_LANES` unpacked: lane results.
- `lane_seq_id`, input, `SEQUENCE_ID_WIDTH` x `NUM_LANES`: sequence tag per lane.
- `lane_valid`, input, 1 x `NUM_LANES`: lane beat present.
- `lane_ready`, output, 1 x `NUM_LANES`: beat accepted this cycle when high together with `lane_valid`.
- `data_out`, output, `BLOCK_WIDTH`: in-order result.
- `data_out_seq_id`, output, `SEQUENCE_ID_WIDTH`: tag of `data_out`.
- `data_out_valid`, output, 1: head entry present.
- `data_out_ready`, input, 1: consumer accepts.
- `occupancy`, output, $clog2(`ROB_DEPTH`+1): number of filled slots.
- `seq_error`, output, 1: sticky flag, set on a duplicate tag.

## Operation
**State**
- `expected_seq` register.
- `ROB_DEPTH` slots; each holds data, seq_id and an occupied bit.
- `occupancy` counter.
- `seq_error` flag.

**Slot mapping and window**
- Slot index = `lane_seq_id[$clog2(ROB_DEPTH)-1:0]`.
- `offset` = `lane_seq_id - expected_seq`, computed modulo 2^`SEQUENCE_ID_WIDTH` from the registered `expected_seq`.

**Per-lane accept decision** (uses only registered state plus the lane inputs):
- `offset < ROB_DEPTH` and slot empty: `lane_ready`=1; the slot is written at the edge and marked occupied.
- `offset >= ROB_DEPTH` (outside the window): `lane_ready`=0. The lane stalls until the window advances.
- `offset < ROB_DEPTH` and slot occupied (duplicate): `lane_ready`=1, beat dropped, `seq_error` set.
- Two lanes present the same in-window tag in the same cycle with the slot empty:
  - The lowest lane index is accepted.
  - The other lanes see `lane_ready`=0.
  - On the following cycle they fall into the duplicate rule.
- There is no combinational path from `data_out_ready` to `lane_ready`.

**Output**
- `data_out_valid` = occupied bit of slot `expected_seq[$clog2(ROB_DEPTH)-1:0]`.
- `data_out` and `data_out_seq_id` come from that slot, through a mux of registered storage.
- Pop when `data_out_valid && data_out_ready`: clear the head occupied bit and increment `expected_seq`, wrapping 2^`SEQUENCE_ID_WIDTH`-1 → 0.

**Simultaneous push and pop** in the same cycle:
- `occupancy` changes by (accepted writes − pops).
- A freed slot is not reusable until the next cycle. A tag mapping to it has offset `ROB_DEPTH` against the pre-pop `expected_seq`, so it is rejected.

**Reset values**, at assertion and during reset:
- All occupied bits = 0 and `expected_seq` = 0.
- Slot storage = 0, so `data_out` = 0 and `data_out_seq_id` = 0.
- `data_out_valid` = 0, `occupancy` = 0, `seq_error` = 0.
- `lane_ready` = 0 while `rst_n` is low.

**Reset mid-operation:** all buffered entries are discarded. The upstream distributor restarts at sequence 0 under the same reset.

## Timing
- Latency:
  - A beat accepted at edge N that matches `expected_seq` drives `data_out_valid`=1 from edge N.
  - Its data is visible in the cycle after edge N.
- Throughput: one output per cycle while in-order data is available.
- Input acceptance: up to `NUM_LANES` beats per cycle.
- `data_out_valid` and its data stay stable while `data_out_ready`=0. The head is never overwritten, because duplicates are dropped.
- `seq_error` clears only on reset.

## Structure
- Shared package `block_pipe_pkg` holds:
  - the default `BLOCK_WIDTH` and `SEQUENCE_ID_WIDTH`;
  - `typedef struct packed {logic [BLOCK_WIDTH-1:0] data; logic [SEQUENCE_ID_WIDTH-1:0] seq_id;} lane_beat_t`.
  - This package is also used by `block_distributor`.
- One sub-module, `seq_window_check`, instantiated per lane. It is purely combinational:
  - inputs: tag, `expected_seq`, occupied vector;
  - outputs: in-window, slot index, duplicate.
- Arbitration, storage, counter and output logic live in the top level.

## Test plan
- **In-order:** lanes 0..3 present tags 0..3 with data `32'hA000_0000`+i, all in one cycle, `data_out_ready`=1. Required: outputs `A000_0000`..`A000_0003` with seq 0..3 on four consecutive cycles; `occupancy` peaks at 4.
- **Out of order:** tag 2 arrives, then tag 1, then tag 0. Required: no output until tag 0 is accepted; then seq 0, 1, 2 on three consecutive cycles.
- **Window stall:** `expected_seq`=0 and a lane presents tag 8 with `ROB_DEPTH`=8. Required: `lane_ready`=0 until seq 0 is popped, then accepted the next cycle.
- **Backpressure and wrap:**
  - Stream tags 250..255, then 0..5, with `data_out_ready` toggling every cycle.
  - Required: output order 250..255, 0..5; no loss; data held while ready is low.
- **Duplicate:** tag 3 is sent twice while unpopped. Required: the second beat has `lane_ready`=1, is dropped, `seq_error`=1, and exactly one seq 3 is output.
- **Mid-stream reset:** fill 5 slots, then pulse `rst_n` low for 3 cycles. Required: `data_out_valid`=0, `occupancy`=0, `seq_error`=0; after release, tag 0 is accepted and output first.
